// File: rtl/falcon_pkg.sv
// ---------------------------------------------------------------------------
// falcon_pkg
// Shared definitions for the small-Gaussian polynomial generator:
//   - data widths for samples, coefficients and coefficient addresses
//   - MAX_FG_BITS table, indexed by logn, giving the coefficient bit budget
//   - controller state enum
//   - helpers that turn a raw logn into the legal degree, the last
//     coefficient index and the acceptance limit
// No ports (package).
// ---------------------------------------------------------------------------
package falcon_pkg;

    localparam int SMP_W    = 32;
    localparam int COEF_W   = 8;
    localparam int ADDR_W   = 10;
    localparam int LOGN_W   = 4;
    localparam int REJ_W    = 16;
    localparam int MAX_LOGN = 10;

    // Bits available to an f/g coefficient for each degree log2(n).
    localparam int MAX_FG_BITS [0:10] = '{0, 8, 8, 8, 8, 8, 7, 7, 6, 6, 5};

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CHECK,
        FIN
    } state_t;

    // Out-of-range degrees fall back to the largest supported one.
    function automatic logic [LOGN_W-1:0] legal_logn(input logic [LOGN_W-1:0] logn);
        if (logn == '0 || logn > LOGN_W'(MAX_LOGN)) begin
            return LOGN_W'(MAX_LOGN);
        end
        return logn;
    endfunction

    // Index of the final coefficient, n-1. For n=1024 the 11-bit result
    // 1023 still fits the 10-bit address.
    function automatic logic [ADDR_W-1:0] last_index(input logic [LOGN_W-1:0] logn);
        logic [ADDR_W:0] n_full;
        n_full = (ADDR_W+1)'(1) << legal_logn(logn);
        return ADDR_W'(n_full - (ADDR_W+1)'(1));
    endfunction

    // Acceptance limit 2^(MAX_FG_BITS-1); samples must lie in [-lim, lim).
    function automatic logic signed [SMP_W-1:0] lim_of(input logic [LOGN_W-1:0] logn);
        int unsigned idx;
        idx = int'(legal_logn(logn));
        return 32'sd1 <<< (MAX_FG_BITS[idx] - 1);
    endfunction

endpackage

// File: rtl/poly_small_gauss_if.sv
// ---------------------------------------------------------------------------
// poly_small_gauss_if
// Bundles the control, sampler and coefficient-write signals of
// poly_small_gauss.
//   start     : one-cycle request to build a polynomial
//   logn      : log2 of the degree, sampled with start
//   smp_req   : one-cycle request for a Gaussian sample
//   val_valid : sample valid from the sampler (may be held several cycles)
//   val       : signed sample value
//   wr_en     : coefficient write strobe
//   wr_addr   : coefficient index
//   wr_data   : signed 8-bit coefficient
//   busy      : generator working on a polynomial
//   done      : one-cycle completion pulse
//   rej_cnt   : saturating count of rejected samples
// master = the side that drives start/logn and supplies samples,
// slave  = the generator itself.
// ---------------------------------------------------------------------------
interface poly_small_gauss_if;
    import falcon_pkg::*;

    logic                     start;
    logic [LOGN_W-1:0]        logn;
    logic                     smp_req;
    logic                     val_valid;
    logic signed [SMP_W-1:0]  val;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [COEF_W-1:0]        wr_data;
    logic                     busy;
    logic                     done;
    logic [REJ_W-1:0]         rej_cnt;

    modport master (
        output start, logn, val_valid, val,
        input  smp_req, wr_en, wr_addr, wr_data, busy, done, rej_cnt
    );

    modport slave (
        input  start, logn, val_valid, val,
        output smp_req, wr_en, wr_addr, wr_data, busy, done, rej_cnt
    );

endinterface

// File: rtl/gauss_accept.sv
// ---------------------------------------------------------------------------
// gauss_accept
// Combinational accept/reject decision for one Gaussian sample.
//   s      : signed sample under test
//   lim    : positive acceptance limit; s must satisfy -lim <= s < lim
//   last   : sample is a candidate for the final coefficient
//   mod2   : parity of the coefficients accepted so far
//   accept : 1 when the sample may be written
// For the final coefficient the total coefficient sum must come out odd,
// so the sample's LSB has to differ from the running parity.
// ---------------------------------------------------------------------------
module gauss_accept
    import falcon_pkg::*;
(
    input  logic signed [SMP_W-1:0] s,
    input  logic signed [SMP_W-1:0] lim,
    input  logic                    last,
    input  logic                    mod2,
    output logic                    accept
);

    logic signed [SMP_W-1:0] neg_lim;
    logic                    in_range;
    logic                    parity_ok;

    assign neg_lim = -lim;

    // Full-width signed compare so large magnitudes never alias into range.
    assign in_range  = (s >= neg_lim) && (s < lim);

    assign parity_ok = !last || (mod2 ^ s[0]);

    assign accept    = in_range && parity_ok;

endmodule

// File: rtl/poly_small_gauss.sv
// ---------------------------------------------------------------------------
// poly_small_gauss
// Builds one polynomial of n = 2^logn small coefficients by drawing signed
// samples from an external Gaussian sampler one at a time, rejecting those
// outside the coefficient range (and, for the last coefficient, those that
// would make the coefficient sum even), and writing each accepted sample
// as an 8-bit coefficient.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset; aborts any polynomial in flight
//   bus   : poly_small_gauss_if.slave (start/logn, sampler handshake,
//           coefficient write port, busy/done/rej_cnt status)
// Latency from smp_req to the matching wr_en is sampler latency + 2.
// ---------------------------------------------------------------------------
module poly_small_gauss
    import falcon_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    poly_small_gauss_if.slave  bus
);

    state_t                   state_q;
    logic [ADDR_W-1:0]        u_q;
    logic [ADDR_W-1:0]        last_idx_q;
    logic signed [SMP_W-1:0]  lim_q;
    logic                     mod2_q;
    logic signed [SMP_W-1:0]  s_q;

    logic                     smp_req_q;
    logic                     wr_en_q;
    logic [ADDR_W-1:0]        wr_addr_q;
    logic [COEF_W-1:0]        wr_data_q;
    logic                     busy_q;
    logic                     done_q;
    logic [REJ_W-1:0]         rej_cnt_q;

    logic                     is_last;
    logic                     accept;

    assign is_last = (u_q == last_idx_q);

    gauss_accept u_accept (
        .s      (s_q),
        .lim    (lim_q),
        .last   (is_last),
        .mod2   (mod2_q),
        .accept (accept)
    );

    // Controller. All outputs are registered; the strobes (smp_req, wr_en,
    // done) default low each cycle so they only ever last one cycle.
    // A new sample is only requested once val_valid has dropped, which
    // keeps a held-high valid from the previous sample from being taken
    // as the answer to the next request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            u_q        <= '0;
            last_idx_q <= '0;
            lim_q      <= '0;
            mod2_q     <= 1'b0;
            s_q        <= '0;
            smp_req_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rej_cnt_q  <= '0;
        end else begin
            smp_req_q <= 1'b0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        u_q        <= '0;
                        mod2_q     <= 1'b0;
                        rej_cnt_q  <= '0;
                        last_idx_q <= last_index(bus.logn);
                        lim_q      <= lim_of(bus.logn);
                        busy_q     <= 1'b1;
                        state_q    <= REQ;
                    end
                end

                REQ: begin
                    if (!bus.val_valid) begin
                        smp_req_q <= 1'b1;
                        state_q   <= WAIT;
                    end
                end

                WAIT: begin
                    if (bus.val_valid) begin
                        s_q     <= bus.val;
                        state_q <= CHECK;
                    end
                end

                CHECK: begin
                    if (accept) begin
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= u_q;
                        wr_data_q <= s_q[COEF_W-1:0];
                        u_q       <= u_q + ADDR_W'(1);
                        if (is_last) begin
                            state_q <= FIN;
                        end else begin
                            mod2_q  <= mod2_q ^ s_q[0];
                            state_q <= REQ;
                        end
                    end else begin
                        if (rej_cnt_q != '1) begin
                            rej_cnt_q <= rej_cnt_q + REJ_W'(1);
                        end
                        state_q <= REQ;
                    end
                end

                FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.smp_req = smp_req_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rej_cnt = rej_cnt_q;

endmodule

// File: tb/tb_poly_small_gauss.sv
// ---------------------------------------------------------------------------
// tb_poly_small_gauss
// Self-checking bench for poly_small_gauss: a table of directed polynomials
// with hand-derived expected coefficients, followed by randomized
// polynomials checked against a behavioural model of the sampling rules.
// The bench plays the role of the Gaussian sampler with configurable
// latency and valid-hold length.
// ---------------------------------------------------------------------------
module tb_poly_small_gauss;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    poly_small_gauss_if bus ();

    poly_small_gauss dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // One directed polynomial: samples offered in order, coefficients
    // expected at addresses 0,1,2..., final reject count and done.
    typedef struct packed {
        logic [3:0]        logn;
        logic [3:0]        ns;
        logic [7:0][31:0]  smp;
        logic [3:0]        hold;
        logic [15:0]       max_cyc;
        logic [3:0]        nw;
        logic [3:0][7:0]   data;
        logic [15:0]       rej;
        logic              done;
        logic              pre_reset;
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs [NVEC];

    int n_cmp = 0;
    int n_bad = 0;

    int     fg_bits [0:10] = '{0, 8, 8, 8, 8, 8, 7, 7, 6, 6, 5};

    int     smp_q [$];
    int     exp_addr [$];
    int     exp_data [$];
    int     exp_rej;
    int     exp_done;
    int     act_addr [$];
    int     act_data [$];
    int     done_cnt;
    int     proto_err;
    int     first_delta;

    logic [3:0] r_lg;
    int         r_hold, r_lat, r_eff, r_lim, r_n, r_used, r_v;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.val_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("reset smp_req", longint'(bus.smp_req), 0);
        check("reset wr_en",   longint'(bus.wr_en),   0);
        check("reset wr_addr", longint'(bus.wr_addr), 0);
        check("reset wr_data", longint'(bus.wr_data), 0);
        check("reset busy",    longint'(bus.busy),    0);
        check("reset done",    longint'(bus.done),    0);
        check("reset rej_cnt", longint'(bus.rej_cnt), 0);
        rst_n = 1'b1;
    endtask

    // Starts a polynomial and acts as the sampler: after each smp_req it
    // waits lat cycles, then presents the next queued sample for hold
    // cycles. Runs until done (plus a few idle cycles) or max_cyc.
    task automatic run_poly(input logic [3:0] lg, input int hold, input int lat,
                            input int max_cyc);
        int  idx, cnt, hold_left, req_cyc, post;
        bit  pending, done_seen;
        act_addr.delete();
        act_data.delete();
        done_cnt    = 0;
        proto_err   = 0;
        first_delta = -1;
        idx = 0; cnt = 0; hold_left = 0; req_cyc = 0; post = 0;
        pending = 1'b0; done_seen = 1'b0;

        @(negedge clk);
        bus.start = 1'b1;
        bus.logn  = lg;
        @(negedge clk);
        bus.start = 1'b0;
        check("start busy",    longint'(bus.busy),    1);
        check("start rej_cnt", longint'(bus.rej_cnt), 0);

        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            if (bus.wr_en) begin
                act_addr.push_back(int'(bus.wr_addr));
                act_data.push_back(int'(bus.wr_data));
                if (first_delta < 0) first_delta = cyc - req_cyc;
            end
            if (bus.done) begin
                done_cnt++;
                done_seen = 1'b1;
                check("busy with done", longint'(bus.busy), 0);
            end
            if (bus.smp_req) begin
                if (bus.val_valid || pending) proto_err++;
                pending = 1'b1;
                cnt     = lat;
                req_cyc = cyc;
            end
            if (hold_left > 0) begin
                hold_left--;
            end else begin
                bus.val_valid = 1'b0;
                bus.val       = $urandom;
            end
            if (pending) begin
                if (cnt > 0) begin
                    cnt--;
                end else if (idx < smp_q.size()) begin
                    bus.val_valid = 1'b1;
                    bus.val       = smp_q[idx];
                    idx++;
                    hold_left = hold - 1;
                    pending   = 1'b0;
                end
            end
            if (done_seen) begin
                post++;
                if (post > 3) break;
            end
        end
        bus.val_valid = 1'b0;
    endtask

    task automatic check_results(input string name, input int lat);
        check({name, " writes"}, act_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size() && i < act_addr.size(); i++) begin
            check($sformatf("%s addr[%0d]", name, i), act_addr[i], exp_addr[i]);
            check($sformatf("%s data[%0d]", name, i), act_data[i], exp_data[i]);
        end
        check({name, " rej_cnt"},  longint'(bus.rej_cnt), exp_rej);
        check({name, " done"},     done_cnt, exp_done);
        check({name, " protocol"}, proto_err, 0);
        if (exp_addr.size() > 0) begin
            check({name, " latency"}, first_delta, lat + 2);
        end
    endtask

    // Reference: degree and limit from the logn rules, then walk the
    // samples, keeping the running coefficient sum so that the final
    // coefficient is accepted only if it makes that sum odd.
    task automatic model_poly(input logic [3:0] lg, output int used);
        int     eff, n, lim, u, rej;
        longint sum;
        eff = (lg == 0 || lg > 10) ? 10 : int'(lg);
        n   = 1 << eff;
        lim = 1 << (fg_bits[eff] - 1);
        exp_addr.delete();
        exp_data.delete();
        u = 0; rej = 0; sum = 0; used = 0; exp_done = 0;
        foreach (smp_q[i]) begin
            if (exp_done != 0) break;
            used++;
            if (smp_q[i] < -lim || smp_q[i] >= lim) begin
                rej++;
            end else if (u == n - 1 && ((sum + smp_q[i]) % 2) == 0) begin
                rej++;
            end else begin
                exp_addr.push_back(u);
                exp_data.push_back(smp_q[i] & 255);
                sum += smp_q[i];
                u++;
                if (u == n) exp_done = 1;
            end
        end
        exp_rej = (rej > 65535) ? 65535 : rej;
    endtask

    task automatic set_vec(input int k, input logic [3:0] lg, input int hold,
                           input int max_cyc, input int rej, input bit done,
                           input bit pre);
        vecs[k]           = '0;
        vecs[k].logn      = lg;
        vecs[k].hold      = 4'(hold);
        vecs[k].max_cyc   = 16'(max_cyc);
        vecs[k].rej       = 16'(rej);
        vecs[k].done      = done;
        vecs[k].pre_reset = pre;
    endtask

    task automatic add_smp(input int k, input int v);
        vecs[k].smp[3'(vecs[k].ns)] = 32'(v);
        vecs[k].ns = vecs[k].ns + 4'd1;
    endtask

    task automatic add_wr(input int k, input int d);
        vecs[k].data[2'(vecs[k].nw)] = 8'(d);
        vecs[k].nw = vecs[k].nw + 4'd1;
    endtask

    task automatic applyStimulus(input int k);
        smp_q.delete();
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < int'(vecs[k].ns); i++) smp_q.push_back(int'(vecs[k].smp[i]));
        for (int i = 0; i < int'(vecs[k].nw); i++) begin
            exp_addr.push_back(i);
            exp_data.push_back(int'(vecs[k].data[i]));
        end
        exp_rej  = int'(vecs[k].rej);
        exp_done = int'(vecs[k].done);
        if (vecs[k].pre_reset) apply_reset();
        run_poly(vecs[k].logn, int'(vecs[k].hold), k % 3, int'(vecs[k].max_cyc));
    endtask

    initial begin
        rst_n         = 1'b1;
        bus.start     = 1'b0;
        bus.logn      = '0;
        bus.val_valid = 1'b0;
        bus.val       = '0;

        // basic run, one out-of-range reject
        set_vec(0, 4'd2, 1, 200, 1, 1'b1, 1'b1);
        add_smp(0, 3); add_smp(0, 200); add_smp(0, -5); add_smp(0, 1); add_smp(0, 2);
        add_wr(0, 8'h03); add_wr(0, 8'hFB); add_wr(0, 8'h01); add_wr(0, 8'h02);
        // parity reject on the last coefficient
        set_vec(1, 4'd2, 1, 200, 1, 1'b1, 1'b0);
        add_smp(1, 3); add_smp(1, -5); add_smp(1, 1); add_smp(1, 3); add_smp(1, 4);
        add_wr(1, 8'h03); add_wr(1, 8'hFB); add_wr(1, 8'h01); add_wr(1, 8'h04);
        // valid held three cycles per sample
        set_vec(2, 4'd1, 3, 200, 0, 1'b1, 1'b0);
        add_smp(2, 7); add_smp(2, 2);
        add_wr(2, 8'h07); add_wr(2, 8'h02);
        // range boundaries at logn=10 (lim=16); polynomial left unfinished
        set_vec(3, 4'd10, 1, 60, 2, 1'b0, 1'b0);
        add_smp(3, 16); add_smp(3, -17); add_smp(3, -16); add_smp(3, 15);
        add_wr(3, 8'hF0); add_wr(3, 8'h0F);
        // two writes, then aborted by the reset before the next vector
        set_vec(4, 4'd2, 1, 40, 0, 1'b0, 1'b1);
        add_smp(4, 3); add_smp(4, -5);
        add_wr(4, 8'h03); add_wr(4, 8'hFB);
        // fresh polynomial after mid-run reset
        set_vec(5, 4'd2, 1, 200, 1, 1'b1, 1'b1);
        add_smp(5, 3); add_smp(5, 200); add_smp(5, -5); add_smp(5, 1); add_smp(5, 2);
        add_wr(5, 8'h03); add_wr(5, 8'hFB); add_wr(5, 8'h01); add_wr(5, 8'h02);

        apply_reset();

        for (int k = 0; k < NVEC; k++) begin
            applyStimulus(k);
            check_results($sformatf("vec%0d", k), k % 3);
        end

        // randomized polynomials, back to back without reset
        for (int r = 0; r < 8; r++) begin
            if (r == 7) r_lg = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'd15;
            else        r_lg = 4'($urandom_range(1, 4));
            r_hold = int'($urandom_range(1, 3));
            r_lat  = int'($urandom_range(0, 3));
            r_eff  = (r_lg == 0 || r_lg > 10) ? 10 : int'(r_lg);
            r_n    = 1 << r_eff;
            r_lim  = 1 << (fg_bits[r_eff] - 1);
            smp_q.delete();
            for (int i = 0; i < 4 * r_n + 40; i++) begin
                if ($urandom_range(0, 3) == 0) r_v = int'($urandom);
                else r_v = int'($urandom_range(0, 2 * r_lim + 3)) - r_lim - 2;
                smp_q.push_back(r_v);
            end
            model_poly(r_lg, r_used);
            run_poly(r_lg, r_hold, r_lat, r_used * (r_lat + r_hold + 6) + 50);
            check_results($sformatf("rand%0d logn=%0d", r, r_lg), r_lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
